// File: rtl/fp16_to_fixed_converter_if.sv
// Streaming handshake bundle for the FP16 -> fixed-point converter.
// The master side feeds FP16 words and accepts results; the slave side is the converter.
interface fp16_to_fixed_converter_if #(
  parameter int OUT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_sat;
  logic                 out_nan;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_nan
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_nan
  );
endinterface

// File: rtl/fp16_to_fixed_converter.sv
// Two-stage valid/ready FP16 -> saturated signed Q(OUT_WIDTH-FRAC_BITS).FRAC_BITS converter.
// Stage 1 classifies the word and aligns the significand; stage 2 saturates and applies the sign.
// Subnormals flush to zero to match the FP16 adder.
module fp16_to_fixed_converter #(
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ROUND_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  fp16_to_fixed_converter_if.slave   bus,
  input  logic                       clear_count,
  output logic [15:0]                sat_count
);
  // Wide enough for m << (FRAC_BITS + 5), the largest left shift, so overflow is seen exactly.
  localparam int MW = OUT_WIDTH + 16;
  localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {CLS_ZERO, CLS_NUM, CLS_INF, CLS_NAN} cls_e;

  // Decode-side wires
  logic [4:0]        w_exp;
  logic [9:0]        w_mant;
  logic [10:0]       w_m;
  logic signed [7:0] w_sh;
  logic [5:0]        w_rsh;
  logic [MW-1:0]     w_shifted;
  logic [MW-1:0]     w_wide;
  logic              w_rbit;
  cls_e              w_cls;

  // Pack-side wires
  logic [OUT_WIDTH-1:0] w_pack;
  logic                 w_sat;
  logic                 w_nan;

  // Handshake wires
  logic w_s2_adv;
  logic w_out_fire;

  // Stage 1 registers
  logic                 r_s1_valid;
  logic                 r_s1_sign;
  logic                 r_s1_ovf;
  cls_e                 r_s1_cls;
  logic [OUT_WIDTH-1:0] r_s1_mag;

  // Stage 2 / output registers
  logic                 r_out_valid;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic                 r_out_sat;
  logic                 r_out_nan;
  logic [15:0]          r_sat_count;

  // NOTE: in_ready depends combinationally on out_ready so a full pipe can accept while draining.
  assign w_s2_adv     = !r_out_valid || bus.out_ready;
  assign w_out_fire   = r_out_valid && bus.out_ready;
  assign bus.in_ready = !r_s1_valid || w_s2_adv;

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;
  assign bus.out_nan   = r_out_nan;
  assign sat_count     = r_sat_count;

  // Classify the incoming word and align {1,mant} to the output binary point, with optional rounding.
  always_comb begin
    w_exp     = bus.in_data[14:10];
    w_mant    = bus.in_data[9:0];
    w_m       = {1'b1, w_mant};
    w_sh      = $signed({3'b000, w_exp}) + 8'(FRAC_BITS - 25);
    w_rsh     = 6'(-w_sh);
    w_rbit    = 1'b0;
    w_shifted = '0;
    if (w_sh >= 0) begin
      w_shifted = MW'(w_m) << w_sh[5:0];
    end else begin
      // Right shifts past the significand naturally leave zero.
      w_shifted = MW'(w_m) >> w_rsh;
      if (ROUND_MODE == 1) begin
        for (int i = 0; i < 11; i++) begin
          if (w_rsh == 6'(i + 1)) w_rbit = w_m[i];
        end
      end
    end
    w_wide = w_shifted + MW'(w_rbit);

    if (w_exp == 5'd0)       w_cls = CLS_ZERO;
    else if (w_exp == 5'h1F) w_cls = (w_mant != 10'd0) ? CLS_NAN : CLS_INF;
    else                     w_cls = CLS_NUM;
  end

  // Saturate the magnitude against the signed output range and apply the sign.
  always_comb begin
    w_pack = '0;
    w_sat  = 1'b0;
    w_nan  = 1'b0;
    case (r_s1_cls)
      CLS_ZERO: w_pack = '0;
      CLS_NAN:  w_nan  = 1'b1;
      CLS_INF: begin
        w_sat  = 1'b1;
        w_pack = r_s1_sign ? MIN_NEG : MAX_POS;
      end
      default: begin
        if (!r_s1_sign) begin
          if (r_s1_ovf || r_s1_mag[OUT_WIDTH-1]) begin
            w_sat  = 1'b1;
            w_pack = MAX_POS;
          end else begin
            w_pack = r_s1_mag;
          end
        end else begin
          // Exactly 2^(W-1) is representable as the most negative value.
          if (r_s1_ovf || (r_s1_mag[OUT_WIDTH-1] && |r_s1_mag[OUT_WIDTH-2:0])) begin
            w_sat  = 1'b1;
            w_pack = MIN_NEG;
          end else begin
            w_pack = -r_s1_mag;
          end
        end
      end
    endcase
  end

  // Stage 1: capture the decoded word whenever the slot is free or being emptied.
  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_ovf   <= 1'b0;
      r_s1_cls   <= CLS_ZERO;
      r_s1_mag   <= '0;
    end else if (bus.in_ready) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_sign <= bus.in_data[15];
        r_s1_ovf  <= |w_wide[MW-1:OUT_WIDTH];
        r_s1_cls  <= w_cls;
        r_s1_mag  <= w_wide[OUT_WIDTH-1:0];
      end
    end
  end

  // Stage 2: register the packed result; hold it while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_nan   <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_pack;
        r_out_sat  <= w_sat;
        r_out_nan  <= w_nan;
      end
    end
  end

  // Count saturated output transfers, sticking at all-ones; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_count <= '0;
    end else if (clear_count) begin
      r_sat_count <= '0;
    end else if (w_out_fire && r_out_sat && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_fp16_to_fixed_converter.sv
// Bench for fp16_to_fixed_converter: directed vector table, hand-written stall/reset/clear
// sequences, then randomized traffic scored against a real-arithmetic reference model.
// Two instances (truncate and round) run in lockstep on identical stimulus.
module tb_fp16_to_fixed_converter;
  localparam int W  = 16;
  localparam int FB = 8;

  typedef struct packed {
    logic [15:0] data;
    logic        sat;
    logic        nan;
  } res_t;

  typedef struct {
    logic [15:0] din;
    logic [15:0] q0;
    logic        sat;
    logic        nan;
    logic [15:0] q1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_count;
  logic [15:0] sat0;
  logic [15:0] sat1;

  fp16_to_fixed_converter_if #(.OUT_WIDTH(W)) bus0 ();
  fp16_to_fixed_converter_if #(.OUT_WIDTH(W)) bus1 ();

  fp16_to_fixed_converter #(.OUT_WIDTH(W), .FRAC_BITS(FB), .ROUND_MODE(0)) u_rm0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .clear_count(clear_count), .sat_count(sat0)
  );
  fp16_to_fixed_converter #(.OUT_WIDTH(W), .FRAC_BITS(FB), .ROUND_MODE(1)) u_rm1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .clear_count(clear_count), .sat_count(sat1)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;
  res_t q0[$];
  res_t q1[$];
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic rdy);
    bus0.in_valid  = v;
    bus0.in_data   = d;
    bus0.out_ready = rdy;
    bus1.in_valid  = v;
    bus1.in_data   = d;
    bus1.out_ready = rdy;
  endtask

  // Reference: value = 1.mant * 2^(exp-15), scaled by 2^FB, then trunc/round and clamp.
  function automatic res_t model(input logic [15:0] w, input int rm);
    res_t r;
    real  x;
    int   mag;
    int   e;
    r = '0;
    e = int'(w[14:10]);
    if (e == 0) return r;
    if (e == 31) begin
      if (w[9:0] != 10'd0) begin
        r.nan = 1'b1;
        return r;
      end
      r.sat  = 1'b1;
      r.data = w[15] ? 16'h8000 : 16'h7FFF;
      return r;
    end
    x = real'(1024 + int'(w[9:0]));
    for (int i = 0; i < e - 25 + FB; i++) x = x * 2.0;
    for (int i = 0; i < 25 - FB - e; i++) x = x / 2.0;
    mag = (rm == 1) ? $rtoi(x + 0.5) : $rtoi(x);
    if (!w[15]) begin
      if (mag > 32767) begin r.sat = 1'b1; r.data = 16'h7FFF; end
      else r.data = 16'(mag);
    end else begin
      if (mag > 32768) begin r.sat = 1'b1; r.data = 16'h8000; end
      else r.data = 16'(-mag);
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    if ($urandom_range(0, 3) == 0) w = 16'($urandom);
    else w = {1'($urandom), 5'($urandom_range(8, 23)), 10'($urandom)};
    return w;
  endfunction

  // One scored cycle: drive, score any output transfer, track sat_count, check hold on stall.
  task automatic rcycle(input logic v, input logic [15:0] d, input logic rdy, input logic clr);
    res_t        e0;
    res_t        e1;
    logic        stall;
    logic [15:0] hd;
    logic        hs;
    logic        hn;
    drive(v, d, rdy);
    clear_count = clr;
    #1;
    stall = bus0.out_valid && !bus0.out_ready;
    hd    = bus0.out_data;
    hs    = bus0.out_sat;
    hn    = bus0.out_nan;
    if (bus0.out_valid && bus0.out_ready) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: output %h with no pending word", bus0.out_data);
      end else begin
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        check("rnd data rm0", bus0.out_data, e0.data);
        check("rnd sat rm0", bus0.out_sat, e0.sat);
        check("rnd nan rm0", bus0.out_nan, e0.nan);
        check("rnd data rm1", bus1.out_data, e1.data);
        if (!clr && e0.sat && exp_cnt != 65535) exp_cnt++;
      end
    end
    if (clr) exp_cnt = 0;
    if (v && bus0.in_ready) begin
      q0.push_back(model(d, 0));
      q1.push_back(model(d, 1));
    end
    @(posedge clk);
    #1;
    check("rnd sat_count rm0", sat0, 32'(exp_cnt));
    check("rnd sat_count rm1", sat1, 32'(exp_cnt));
    if (stall) begin
      check("hold valid", bus0.out_valid, 1);
      check("hold data", bus0.out_data, hd);
      check("hold flags", {bus0.out_sat, bus0.out_nan}, {hs, hn});
    end
  endtask

  initial begin
    vecs[0]  = '{16'h3C00, 16'h0100, 1'b0, 1'b0, 16'h0100};
    vecs[1]  = '{16'hC000, 16'hFE00, 1'b0, 1'b0, 16'hFE00};
    vecs[2]  = '{16'h5800, 16'h7FFF, 1'b1, 1'b0, 16'h7FFF};
    vecs[3]  = '{16'hD800, 16'h8000, 1'b0, 1'b0, 16'h8000};
    vecs[4]  = '{16'h7C00, 16'h7FFF, 1'b1, 1'b0, 16'h7FFF};
    vecs[5]  = '{16'hFC00, 16'h8000, 1'b1, 1'b0, 16'h8000};
    vecs[6]  = '{16'h7E00, 16'h0000, 1'b0, 1'b1, 16'h0000};
    vecs[7]  = '{16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{16'h8000, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{16'h1800, 16'h0000, 1'b0, 1'b0, 16'h0001};
    vecs[10] = '{16'h1C00, 16'h0001, 1'b0, 1'b0, 16'h0001};
    vecs[11] = '{16'h3E00, 16'h0180, 1'b0, 1'b0, 16'h0180};
    vecs[12] = '{16'h2E00, 16'h0018, 1'b0, 1'b0, 16'h0018};
    vecs[13] = '{16'h57FF, 16'h7FF0, 1'b0, 1'b0, 16'h7FF0};
    vecs[14] = '{16'hD7FF, 16'h8010, 1'b0, 1'b0, 16'h8010};
    vecs[15] = '{16'h3C03, 16'h0100, 1'b0, 1'b0, 16'h0101};
    vecs[16] = '{16'hBC03, 16'hFF00, 1'b0, 1'b0, 16'hFEFF};

    rst = 1'b1;
    clear_count = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);
    #12;
    check("reset out_valid", bus0.out_valid, 0);
    check("reset sat_count", sat0, 0);
    check("reset out_data", bus0.out_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset in_ready", bus0.in_ready, 1);
    @(posedge clk);
    #1;

    // Directed vectors: one word at a time, checking the two-cycle latency and sat_count.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, vecs[i].din, 1'b1);
      @(posedge clk);
      #1;
      drive(1'b0, 16'h0000, 1'b1);
      check($sformatf("vec%0d latency1", i), bus0.out_valid, 0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d latency2", i), bus0.out_valid, 1);
      check($sformatf("vec%0d data rm0", i), bus0.out_data, vecs[i].q0);
      check($sformatf("vec%0d sat", i), bus0.out_sat, vecs[i].sat);
      check($sformatf("vec%0d nan", i), bus0.out_nan, vecs[i].nan);
      check($sformatf("vec%0d data rm1", i), bus1.out_data, vecs[i].q1);
      if (vecs[i].sat) exp_cnt++;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d sat_count", i), sat0, 32'(exp_cnt));
      check($sformatf("vec%0d drained", i), bus0.out_valid, 0);
    end

    // Back-pressure: two words fill the pipe, the third is refused until out_ready rises.
    drive(1'b1, 16'h3C00, 1'b0);
    #1;
    check("bp accept1", bus0.in_ready, 1);
    @(posedge clk);
    #1;
    drive(1'b1, 16'h4000, 1'b0);
    #1;
    check("bp accept2", bus0.in_ready, 1);
    @(posedge clk);
    #1;
    drive(1'b1, 16'h4200, 1'b0);
    #1;
    check("bp in_ready low", bus0.in_ready, 0);
    check("bp stall data1", bus0.out_data, 16'h0100);
    @(posedge clk);
    #1;
    drive(1'b1, 16'h4200, 1'b1);
    #1;
    check("bp stall valid", bus0.out_valid, 1);
    check("bp stall data2", bus0.out_data, 16'h0100);
    check("bp release in_ready", bus0.in_ready, 1);
    @(posedge clk);
    #1;
    drive(1'b0, 16'h0000, 1'b1);
    check("bp out2 valid", bus0.out_valid, 1);
    check("bp out2 data", bus0.out_data, 16'h0200);
    @(posedge clk);
    #1;
    check("bp out3 valid", bus0.out_valid, 1);
    check("bp out3 data", bus0.out_data, 16'h0300);
    @(posedge clk);
    #1;
    check("bp empty", bus0.out_valid, 0);

    // Asynchronous reset with both stages full.
    drive(1'b1, 16'h7C00, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 16'h3C00, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 16'h0000, 1'b0);
    check("pre-reset valid", bus0.out_valid, 1);
    rst = 1'b1;
    #1;
    check("async rst out_valid", bus0.out_valid, 0);
    check("async rst sat_count", sat0, 0);
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 16'h0000, 1'b1);
    #1;
    check("post-rst in_ready", bus0.in_ready, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("post-rst discarded", bus0.out_valid, 0);

    // A saturating transfer counts; a second one coinciding with clear_count leaves zero.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 16'hFC00, 1'b1);
      @(posedge clk);
      #1;
      drive(1'b0, 16'h0000, 1'b1);
      @(posedge clk);
      #1;
      check($sformatf("clr%0d sat out", k), bus0.out_sat, 1);
      clear_count = (k == 1);
      @(posedge clk);
      #1;
      clear_count = 1'b0;
      check($sformatf("clr%0d sat_count", k), sat0, (k == 0) ? 32'd1 : 32'd0);
    end
    exp_cnt = 0;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      rcycle($urandom_range(0, 9) < 7, rand_word(), $urandom_range(0, 9) < 7,
             $urandom_range(0, 24) == 0);
    end
    for (int k = 0; k < 20 && q0.size() > 0; k++) rcycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check("drain scoreboard empty", 32'(q0.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
